// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates three memory clients (instruction fetch, load unit, store buffer)
// onto a single-transaction word-wide memory controller. One client is picked
// in IDLE, its request is held stable while BUSY, and the result is returned
// to that client only with a one-cycle ack pulse in RESP.
// Priority is store > load > fetch. A fetch that has lost STARVE_LIMIT
// consecutive grants is forced through. A flush kills a speculative
// fetch/load in flight, suppressing its ack and rdata update.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush_i                branch mispredict, kills speculative fetch/load
//   if_req_i/if_addr_i     fetch request/address; if_ack_o/if_rdata_o reply
//   ld_req_i/ld_addr_i     load request/address;  ld_ack_o/ld_rdata_o reply
//   st_req_i/st_addr_i/st_wdata_i   store request; st_ack_o reply
//   ctl_req_o/ctl_we_o/ctl_addr_o/ctl_wdata_o   controller transaction
//   ctl_rdata_i/ctl_done_i completion pulse and read data from controller
//   busy_o                 high while a transaction is outstanding or acking
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        ld_req_i,
  input  logic [31:0] ld_addr_i,
  output logic        ld_ack_o,
  output logic [31:0] ld_rdata_o,
  input  logic        st_req_i,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_wdata_i,
  output logic        st_ack_o,
  output logic        ctl_req_o,
  output logic        ctl_we_o,
  output logic [31:0] ctl_addr_o,
  output logic [31:0] ctl_wdata_o,
  input  logic [31:0] ctl_rdata_i,
  input  logic        ctl_done_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD, OWN_ST} owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        kill_q, kill_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic        ctl_req_q, ctl_req_d;
  logic        ctl_we_q, ctl_we_d;
  logic [31:0] ctl_addr_q, ctl_addr_d;
  logic [31:0] ctl_wdata_q, ctl_wdata_d;
  logic        if_ack_q, if_ack_d;
  logic        ld_ack_q, ld_ack_d;
  logic        st_ack_q, st_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] ld_rdata_q, ld_rdata_d;
  logic        starved;

  assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

  // Next-state logic. Acks default low so they only last the RESP cycle.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    kill_d      = kill_q;
    starve_d    = starve_q;
    ctl_req_d   = ctl_req_q;
    ctl_we_d    = ctl_we_q;
    ctl_addr_d  = ctl_addr_q;
    ctl_wdata_d = ctl_wdata_q;
    if_ack_d    = 1'b0;
    ld_ack_d    = 1'b0;
    st_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ld_rdata_d  = ld_rdata_q;

    unique case (state_q)
      IDLE: begin
        kill_d  = 1'b0;
        owner_d = OWN_NONE;
        // Starvation override beats the fixed priority order.
        if (if_req_i && !flush_i && starved) owner_d = OWN_IF;
        else if (st_req_i)                   owner_d = OWN_ST;
        else if (ld_req_i && !flush_i)       owner_d = OWN_LD;
        else if (if_req_i && !flush_i)       owner_d = OWN_IF;

        if (owner_d != OWN_NONE) begin
          state_d     = BUSY;
          ctl_req_d   = 1'b1;
          ctl_we_d    = (owner_d == OWN_ST);
          ctl_wdata_d = (owner_d == OWN_ST) ? st_wdata_i : 32'h0;
          case (owner_d)
            OWN_IF:  ctl_addr_d = if_addr_i;
            OWN_LD:  ctl_addr_d = ld_addr_i;
            default: ctl_addr_d = st_addr_i;
          endcase
        end

        // Count only grants a waiting fetch lost; any fetch grant or an
        // absent fetch request restarts the count.
        if (!if_req_i || owner_d == OWN_IF) starve_d = '0;
        else if (owner_d != OWN_NONE && !starved) starve_d = starve_q + CNT_W'(1);
      end

      BUSY: begin
        // The controller cannot abort, so a flushed speculative owner just
        // has its result discarded when the transaction completes.
        if (flush_i && owner_q != OWN_ST) kill_d = 1'b1;
        if (ctl_done_i) begin
          ctl_req_d = 1'b0;
          state_d   = RESP;
          case (owner_q)
            OWN_ST: st_ack_d = 1'b1;
            OWN_IF: if (!kill_q && !flush_i) begin
              if_ack_d   = 1'b1;
              if_rdata_d = ctl_rdata_i;
            end
            OWN_LD: if (!kill_q && !flush_i) begin
              ld_ack_d   = 1'b1;
              ld_rdata_d = ctl_rdata_i;
            end
            default: ;
          endcase
        end
      end

      RESP: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase

    if (flush_i) starve_d = '0;
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      kill_q      <= 1'b0;
      starve_q    <= '0;
      ctl_req_q   <= 1'b0;
      ctl_we_q    <= 1'b0;
      ctl_addr_q  <= 32'h0;
      ctl_wdata_q <= 32'h0;
      if_ack_q    <= 1'b0;
      ld_ack_q    <= 1'b0;
      st_ack_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      ld_rdata_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      kill_q      <= kill_d;
      starve_q    <= starve_d;
      ctl_req_q   <= ctl_req_d;
      ctl_we_q    <= ctl_we_d;
      ctl_addr_q  <= ctl_addr_d;
      ctl_wdata_q <= ctl_wdata_d;
      if_ack_q    <= if_ack_d;
      ld_ack_q    <= ld_ack_d;
      st_ack_q    <= st_ack_d;
      if_rdata_q  <= if_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign ld_ack_o    = ld_ack_q;
  assign ld_rdata_o  = ld_rdata_q;
  assign st_ack_o    = st_ack_q;
  assign ctl_req_o   = ctl_req_q;
  assign ctl_we_o    = ctl_we_q;
  assign ctl_addr_o  = ctl_addr_q;
  assign ctl_wdata_o = ctl_wdata_q;
  assign busy_o      = (state_q == BUSY) || (state_q == RESP);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: random client/controller traffic checked every
// cycle against a transaction-level reference of the arbitration rules.
module tb_mem_arbiter;

   localparam int LIMIT = 4;
   localparam int MODE_RANDOM = 0;
   localparam int MODE_PRESS  = 1;
   localparam int MODE_QUIET  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush_i = 1'b0;
   logic        if_req_i = 1'b0, ld_req_i = 1'b0, st_req_i = 1'b0;
   logic [31:0] if_addr_i = '0, ld_addr_i = '0, st_addr_i = '0, st_wdata_i = '0;
   logic        if_ack_o, ld_ack_o, st_ack_o;
   logic [31:0] if_rdata_o, ld_rdata_o;
   logic        ctl_req_o, ctl_we_o;
   logic [31:0] ctl_addr_o, ctl_wdata_o;
   logic [31:0] ctl_rdata_i = '0;
   logic        ctl_done_i = 1'b0;
   logic        busy_o;

   mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
      .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_ack_o(ld_ack_o), .ld_rdata_o(ld_rdata_o),
      .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_wdata_i(st_wdata_i), .st_ack_o(st_ack_o),
      .ctl_req_o(ctl_req_o), .ctl_we_o(ctl_we_o), .ctl_addr_o(ctl_addr_o),
      .ctl_wdata_o(ctl_wdata_o), .ctl_rdata_i(ctl_rdata_i), .ctl_done_i(ctl_done_i),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference: a transaction is either absent, outstanding at the
   // controller, or being acknowledged; clients are 1=fetch 2=load 3=store.
   int          txPhase;
   int          txOwner;
   int          winner;
   bit          txKilled;
   int          starveCount;
   bit          expReq, expWe, expIfAck, expLdAck, expStAck;
   logic [31:0] expAddr, expWdata, expIfData, expLdData;

   // Controller environment state.
   bit          ctlActive;
   int          ctlWait;
   int          fixedLat = -1;
   bit          useFixedData = 1'b0;
   logic [31:0] fixedData = '0;
   bit          injectDone = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   task modelReset();
      txPhase = 0; txOwner = 0; txKilled = 0; starveCount = 0;
      expReq = 0; expWe = 0; expIfAck = 0; expLdAck = 0; expStAck = 0;
      expAddr = '0; expWdata = '0; expIfData = '0; expLdData = '0;
   endtask

   task modelStep();
      expIfAck = 0; expLdAck = 0; expStAck = 0;
      if (txPhase == 2) begin
         txPhase = 0;
      end else if (txPhase == 1) begin
         if (flush_i && txOwner != 3) txKilled = 1;
         if (ctl_done_i) begin
            expReq = 0;
            txPhase = 2;
            if (txOwner == 3) expStAck = 1;
            else if (!txKilled && txOwner == 1) begin expIfAck = 1; expIfData = ctl_rdata_i; end
            else if (!txKilled && txOwner == 2) begin expLdAck = 1; expLdData = ctl_rdata_i; end
         end
      end else begin
         txKilled = 0;
         winner = 0;
         if (if_req_i && !flush_i && starveCount == LIMIT) winner = 1;
         else if (st_req_i) winner = 3;
         else if (ld_req_i && !flush_i) winner = 2;
         else if (if_req_i && !flush_i) winner = 1;
         if (winner != 0) begin
            txOwner = winner;
            txPhase = 1;
            expReq = 1;
            expWe = (winner == 3);
            expAddr = (winner == 1) ? if_addr_i : (winner == 2) ? ld_addr_i : st_addr_i;
            expWdata = (winner == 3) ? st_wdata_i : 32'h0;
         end
         if (!if_req_i || winner == 1) starveCount = 0;
         else if (winner != 0 && starveCount < LIMIT) starveCount++;
      end
      if (flush_i) starveCount = 0;
   endtask

   // Reference advances on the same events as the design.
   initial begin
      modelReset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) modelReset();
         else modelStep();
      end
   end

   task compareAll();
      checkOutput("ctl_req", ctl_req_o, expReq);
      checkOutput("ctl_we", ctl_we_o, expWe);
      checkOutput("ctl_addr", ctl_addr_o, expAddr);
      checkOutput("ctl_wdata", ctl_wdata_o, expWdata);
      checkOutput("if_ack", if_ack_o, expIfAck);
      checkOutput("ld_ack", ld_ack_o, expLdAck);
      checkOutput("st_ack", st_ack_o, expStAck);
      checkOutput("if_rdata", if_rdata_o, expIfData);
      checkOutput("ld_rdata", ld_rdata_o, expLdData);
      checkOutput("busy", busy_o, txPhase != 0);
   endtask

   // One cycle: check outputs at the falling edge, then drive new inputs.
   task applyStimulus(input int mode);
      @(negedge clk);
      compareAll();
      if (if_ack_o) if_req_i = 0;
      if (ld_ack_o) ld_req_i = 0;
      if (st_ack_o) st_req_i = 0;

      flush_i = (mode == MODE_RANDOM) && ($urandom_range(0, 11) == 0);
      if (flush_i) begin
         if_req_i = 0;
         ld_req_i = 0;
      end
      if (mode != MODE_QUIET && !flush_i) begin
         if (!if_req_i && (mode == MODE_PRESS || $urandom_range(0, 2) == 0)) begin
            if_req_i = 1; if_addr_i = {4'h1, 28'($urandom)};
         end
         if (!ld_req_i && (mode == MODE_PRESS || $urandom_range(0, 2) == 0)) begin
            ld_req_i = 1; ld_addr_i = {4'h2, 28'($urandom)};
         end
         if (!st_req_i && (mode == MODE_PRESS || $urandom_range(0, 3) == 0)) begin
            st_req_i = 1; st_addr_i = {4'h3, 28'($urandom)}; st_wdata_i = $urandom;
         end
      end
      // Held requests wiggle their address to show the grant is latched.
      if (mode == MODE_RANDOM && $urandom_range(0, 3) == 0) begin
         if_addr_i = {4'h1, 28'($urandom)};
         ld_addr_i = {4'h2, 28'($urandom)};
         st_addr_i = {4'h3, 28'($urandom)};
         st_wdata_i = $urandom;
      end

      ctl_done_i = 0;
      if (ctl_req_o && !ctlActive) begin
         ctlActive = 1;
         ctlWait = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 4));
      end
      if (ctlActive) begin
         if (ctlWait == 0) begin
            ctl_done_i = 1;
            ctl_rdata_i = useFixedData ? fixedData : $urandom;
            ctlActive = 0;
         end else begin
            ctlWait--;
         end
      end
      if (injectDone) begin
         ctl_done_i = 1;
         ctl_rdata_i = 32'hBAD0_0BAD;
         injectDone = 0;
      end
   endtask

   task runCycles(input int n, input int mode);
      for (int i = 0; i < n; i++) applyStimulus(mode);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int budget;
      ctlActive = 0;
      ctlWait = 0;
      runCycles(3, MODE_QUIET);
      rst_n = 1;
      runCycles(2, MODE_QUIET);

      // Single fetch with a fixed controller reply.
      $display("[TB] single fetch");
      fixedLat = 3; useFixedData = 1; fixedData = 32'h0011_2233;
      if_req_i = 1; if_addr_i = 32'h0000_0010;
      runCycles(12, MODE_QUIET);

      // All three clients at once: store, then load, then fetch.
      $display("[TB] priority");
      useFixedData = 0; fixedLat = 1;
      st_req_i = 1; st_addr_i = 32'h100; st_wdata_i = 32'hDEADBEEF;
      ld_req_i = 1; ld_addr_i = 32'h200;
      if_req_i = 1; if_addr_i = 32'h0;
      runCycles(20, MODE_QUIET);
      fixedLat = -1;

      $display("[TB] random traffic");
      runCycles(1500, MODE_RANDOM);

      // Store and load never let go, so only the override lets fetch in.
      $display("[TB] starvation pressure");
      runCycles(300, MODE_PRESS);
      runCycles(15, MODE_QUIET);
      runCycles(800, MODE_RANDOM);

      // Asynchronous reset between edges while a transaction is open.
      $display("[TB] async reset");
      budget = 200;
      while (txPhase != 1 && budget > 0) begin
         applyStimulus(MODE_RANDOM);
         budget--;
      end
      if (budget == 0) checkOutput("reset_wait_busy", txPhase, 1);
      #2 rst_n = 0;
      #1;
      checkOutput("rst_ctl_req", ctl_req_o, 0);
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_ctl_addr", ctl_addr_o, 0);
      if_req_i = 0; ld_req_i = 0; st_req_i = 0; flush_i = 0;
      ctl_done_i = 0; ctlActive = 0;
      runCycles(2, MODE_QUIET);
      rst_n = 1;
      injectDone = 1;
      runCycles(6, MODE_QUIET);
      runCycles(200, MODE_RANDOM);
      runCycles(15, MODE_QUIET);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
